anticipator_update: RTL
=======================

// Module: anticipator_update
// PURPOSE
//  Write-side companion of the loop/branch anticipator table (4096 x 2-bit saturating counters).
//  Accepts resolved-branch outcomes from retire, buffers them, and performs read-modify-write of the
//  counter through the table's read port and single write port. After reset or flush it sweeps the
//  whole table to INIT_VAL. Sits between the retire/branch-resolve unit and the anticipator RAM.
// PARAMETERS
//  ADDR_W    12     table index width (table has 2**ADDR_W entries)
//  DEPTH     4      update FIFO entries (power of two, >=2)
//  INIT_VAL  2'b01  counter value written by the init sweep (weakly not-taken)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  flush      in   1       synchronous: discard pending updates, restart init sweep
//  upd_valid  in   1       update request valid
//  upd_ready  out  1       update accepted when upd_valid&&upd_ready at clk edge
//  upd_addr   in   ADDR_W  table index of resolved branch
//  upd_taken  in   1       1 = taken (increment), 0 = not taken (decrement)
//  rd_addr    out  ADDR_W  table read address (table read data is combinational)
//  rd_data    in   2       counter at rd_addr, same cycle
//  wr_en      out  1       table write enable
//  wr_addr    out  ADDR_W  table write address
//  wr_data    out  2       table write data
//  init_busy  out  1       1 while init sweep in progress
// BEHAVIOUR
//  - Reset: state=INIT, sweep counter=0, FIFO empty, W stage invalid; wr_en=0, wr_addr=0,
//    wr_data=0, rd_addr=0, init_busy=1, upd_ready=1. All outputs registered except upd_ready.
//  - upd_ready = !fifo_full && !flush. Updates are accepted in both INIT and RUN; in INIT they wait.
//  - FSM INIT: each cycle wr_en=1, wr_addr=cnt, wr_data=INIT_VAL (registered, 1 cycle after cnt);
//    cnt increments 0..2**ADDR_W-1; after writing the last entry -> RUN, init_busy=0 next cycle.
//    Exactly 2**ADDR_W writes per sweep; no FIFO pops during INIT.
//  - FSM RUN, stage R: if FIFO non-empty pop head, rd_addr=head.addr, old = forward ? W.new : rd_data.
//    new = taken ? sat_inc(old) : sat_dec(old); 2'b11+taken=2'b11, 2'b00+not-taken=2'b00.
//  - Stage W (registered from R): if new!=old then wr_en=1, wr_addr, wr_data=new; else wr_en=0
//    (no redundant write). One pop and at most one write per cycle; throughput 1 update/cycle.
//  - Forwarding: when R.addr==W.addr and W valid, R uses W.new (write not yet visible in table).
//  - Latency: accepted at edge N with FIFO empty in RUN -> popped cycle N+1 -> wr_en high cycle N+2.
//  - FIFO: in-order; push and pop same cycle when full is allowed only via pop first (ready stays
//    !full, no bypass). Pointers wrap modulo DEPTH.
//  - flush (RUN or INIT): next cycle FIFO empty, W stage invalid (in-flight write cancelled),
//    cnt=0, state=INIT, init_busy=1; upd_valid in a flush cycle is not accepted.
//  - Reset mid-sweep or mid-update: all of above reset values, pending updates lost.
// TESTING
//  1 Reset release -> wr_en=1 for exactly 4096 consecutive cycles, wr_addr 0..4095, wr_data=2'b01;
//    init_busy falls the cycle after last write.
//  2 RUN, table[0x123]=01, upd(0x123,taken) at edge N -> wr_en@N+2, wr_addr=0x123, wr_data=2'b10.
//  3 table[0x040]=11, upd taken -> no write; table[0x041]=00, upd not-taken -> no write.
//  4 Back-to-back 3x upd(0x200,taken) from 01 (table model stale) -> writes 10, then 11, then none.
//  5 During INIT push 4 updates, 5th sees upd_ready=0; after sweep they retire in order, 1/cycle.
//  6 flush with 2 queued + 1 in W -> none of them written; new 4096-write sweep starts next cycle.

Source files
------------

// File: rtl/anticipator_update.sv
// Read-modify-write updater for the 2-bit anticipator counter table, plus init sweep after reset/flush.
// Latency accept->write 2 cycles; upd_ready drops when the update FIFO is full or during flush.
module anticipator_update #(
    parameter int         ADDR_W   = 12,
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_VAL = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic              upd_taken,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        wr_data,
    output logic              init_busy
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DEPTH-1:0]  q_taken;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     head_idx_n;
    logic [PW:0]       count;

    logic              w_vld;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_new;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              fwd;
    logic [1:0]        old_val;
    logic [1:0]        new_val;
    logic [ADDR_W-1:0] rd_addr_n;

    always_comb begin
        full      = (count == FULL_CNT);
        empty     = (count == '0);
        upd_ready = !full && !flush;
        push      = upd_valid && upd_ready;
        pop       = (state == S_RUN) && !empty && !flush;

        // rd_addr always holds the FIFO head, so the table read is ready in the pop cycle
        fwd       = w_vld && (w_addr == rd_addr);
        old_val   = fwd ? w_new : rd_data;
        new_val   = old_val;
        if (q_taken[rd_ptr]) begin
            if (old_val != 2'b11) new_val = old_val + 2'b01;
        end else begin
            if (old_val != 2'b00) new_val = old_val - 2'b01;
        end

        head_idx_n = rd_ptr + PW'(pop);
        rd_addr_n  = (push && (wr_ptr == head_idx_n)) ? upd_addr : q_addr[head_idx_n];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr]  <= upd_addr;
            q_taken[wr_ptr] <= upd_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_INIT;
            cnt       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            w_vld     <= 1'b0;
            w_addr    <= '0;
            w_new     <= 2'b00;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 2'b00;
            init_busy <= 1'b1;
        end else if (flush) begin
            state     <= S_INIT;
            cnt       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            w_vld     <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            init_busy <= 1'b1;
        end else begin
            rd_ptr    <= head_idx_n;
            wr_ptr    <= wr_ptr + PW'(push);
            count     <= count + (PW+1)'(push) - (PW+1)'(pop);
            rd_addr   <= rd_addr_n;
            init_busy <= (state == S_INIT);
            case (state)
                S_INIT: begin
                    wr_en   <= 1'b1;
                    wr_addr <= cnt;
                    wr_data <= INIT_VAL;
                    cnt     <= cnt + ADDR_W'(1);
                    w_vld   <= 1'b0;
                    if (cnt == '1) begin
                        state <= S_RUN;
                        // Last sweep write lands together with the first pop; forward it
                        w_vld  <= 1'b1;
                        w_addr <= '1;
                        w_new  <= INIT_VAL;
                    end
                end
                default: begin
                    w_vld  <= pop;
                    w_addr <= rd_addr;
                    w_new  <= new_val;
                    wr_en  <= pop && (new_val != old_val);
                    if (pop) begin
                        wr_addr <= rd_addr;
                        wr_data <= new_val;
                    end
                end
            endcase
        end
    end

endmodule
